// File: rtl/data_sram_responder_if.sv
// Data-side sram-like bus between the core (master) and the data memory responder (slave).
interface data_sram_responder_if;
    // Handshake: a request transfers on a rising edge where req and addr_ok are both high; the
    // master holds req, wr, size, addr, wstrb and wdata stable until then. data_ok is a one-cycle
    // pulse per accepted request, in acceptance order, and cannot be back-pressured.
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data memory responder: byte-strobed word array with a fixed-latency, in-order response pipe
// and an outstanding-request limit that throttles addr_ok.
module data_sram_responder #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_sram_responder_if.slave bus,
    output logic [2:0]           cnt
);
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] waddr;
    logic              accept;
    logic              data_ok;
    logic [LAT-1:0]    pipe_vld;
    logic [LAT-1:0]    pipe_ld;
    logic [31:0]       pipe_data [LAT];
    logic [LAT-1:0]    in_vld;
    logic [LAT-1:0]    in_ld;
    logic [31:0]       in_data [LAT];
    logic              unused_bits;

    assign waddr       = bus.addr[ADDR_W+1:2];
    assign bus.addr_ok = (cnt < 3'(DEPTH));
    assign accept      = bus.req & bus.addr_ok;
    assign data_ok     = pipe_vld[LAT-1];
    assign bus.data_ok = data_ok;
    // The last data stage doubles as the rdata holding register.
    assign bus.rdata   = pipe_data[LAT-1];
    assign unused_bits = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0], pipe_ld[LAT-1]};

    always_ff @(posedge clk) begin
        if (resetn && accept && bus.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    // Input of each pipe stage; stage 0 samples the array before this edge's store lands.
    always_comb begin
        in_vld = '0;
        in_ld  = '0;
        for (int i = 0; i < LAT; i++) in_data[i] = 32'h0;
        in_vld[0]  = accept;
        in_ld[0]   = accept & ~bus.wr;
        in_data[0] = in_ld[0] ? mem[waddr] : 32'h0;
        for (int i = 1; i < LAT; i++) begin
            in_vld[i]  = pipe_vld[i-1];
            in_ld[i]   = pipe_ld[i-1];
            in_data[i] = pipe_data[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pipe_vld         <= '0;
            pipe_ld          <= '0;
            pipe_data[LAT-1] <= 32'h0;
        end else begin
            pipe_vld <= in_vld;
            pipe_ld  <= in_ld;
            for (int i = 0; i < LAT - 1; i++) pipe_data[i] <= in_data[i];
            if (in_vld[LAT-1] && in_ld[LAT-1]) pipe_data[LAT-1] <= in_data[LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= 3'd0;
        end else if (accept && !data_ok) begin
            cnt <= cnt + 3'd1;
        end else if (!accept && data_ok) begin
            cnt <= cnt - 3'd1;
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: scoreboarded main instance (LAT=2, DEPTH=2) plus a
// back-pressure instance (LAT=3, DEPTH=2) checked against a cycle-level occupancy model.
module tb_data_sram_responder;
    localparam int LAT_A = 2, DEPTH_A = 2, LAT_B = 3, DEPTH_B = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] cnt_a, cnt_b;
    int         n_tests = 0, n_fail = 0, cyc = 0;

    data_sram_responder_if a_if ();
    data_sram_responder_if b_if ();

    data_sram_responder #(.ADDR_W(10), .LAT(LAT_A), .DEPTH(DEPTH_A)) u_dut (
        .clk(clk), .resetn(resetn), .bus(a_if.slave), .cnt(cnt_a));
    data_sram_responder #(.ADDR_W(10), .LAT(LAT_B), .DEPTH(DEPTH_B)) u_bp (
        .clk(clk), .resetn(resetn), .bus(b_if.slave), .cnt(cnt_b));

    always #5 clk = ~clk;

    // Reference state for instance A.
    logic [31:0] model_mem [1024];
    logic [31:0] exp_q[$];
    bit          ld_q[$];
    int          due_q[$];
    int          cnt_m_a = 0;
    logic [31:0] exp_rdata = 32'h0;
    // Reference state for instance B.
    int          b_due_q[$];
    int          cnt_m_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Outputs are compared mid-cycle, then the coming rising edge is applied to the model.
    always @(negedge clk) begin : mon
        bit          due, acc;
        logic [31:0] w;
        int          wi;
        cyc++;
        due = (due_q.size() > 0) && (due_q[0] == cyc);
        check("a_addr_ok", 32'(a_if.addr_ok), 32'(cnt_m_a < DEPTH_A));
        check("a_data_ok", 32'(a_if.data_ok), 32'(due));
        check("a_cnt", 32'(cnt_a), 32'(cnt_m_a));
        if (due) begin
            void'(due_q.pop_front());
            w = exp_q.pop_front();
            if (ld_q.pop_front()) exp_rdata = w;
        end
        check("a_rdata", a_if.rdata, exp_rdata);
        if (!resetn) begin
            due_q.delete(); exp_q.delete(); ld_q.delete();
            cnt_m_a = 0;
            exp_rdata = 32'h0;
        end else begin
            acc = a_if.req && (cnt_m_a < DEPTH_A);
            if (acc) begin
                wi = int'(a_if.addr[11:2]);
                if (a_if.wr) begin
                    for (int b = 0; b < 4; b++)
                        if (a_if.wstrb[b]) model_mem[wi][8*b +: 8] = a_if.wdata[8*b +: 8];
                    exp_q.push_back(32'h0);
                    ld_q.push_back(1'b0);
                end else begin
                    exp_q.push_back(model_mem[wi]);
                    ld_q.push_back(1'b1);
                end
                due_q.push_back(cyc + LAT_A);
            end
            cnt_m_a = cnt_m_a + int'(acc) - int'(due);
        end

        due = (b_due_q.size() > 0) && (b_due_q[0] == cyc);
        check("b_addr_ok", 32'(b_if.addr_ok), 32'(cnt_m_b < DEPTH_B));
        check("b_data_ok", 32'(b_if.data_ok), 32'(due));
        check("b_cnt_max", 32'(cnt_b <= 3'd2), 32'd1);
        if (due) void'(b_due_q.pop_front());
        if (!resetn) begin
            b_due_q.delete();
            cnt_m_b = 0;
        end else begin
            acc = b_if.req && (cnt_m_b < DEPTH_B);
            if (acc) b_due_q.push_back(cyc + LAT_B);
            cnt_m_b = cnt_m_b + int'(acc) - int'(due);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] data);
        int waited = 0;
        a_if.req = 1'b1; a_if.wr = wr; a_if.size = 2'd2;
        a_if.addr = addr; a_if.wstrb = strb; a_if.wdata = data;
        @(negedge clk);
        while (!a_if.addr_ok && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check("a_accept", 32'(a_if.addr_ok), 32'd1);
        @(posedge clk);
        #1;
        a_if.req = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (due_q.size() > 0 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("a_drain", 32'(due_q.size()), 32'd0);
    endtask

    initial begin
        a_if.req = 0; a_if.wr = 0; a_if.size = 0; a_if.addr = 0; a_if.wstrb = 0; a_if.wdata = 0;
        b_if.req = 0; b_if.wr = 0; b_if.size = 2'd2; b_if.addr = 0; b_if.wstrb = 0; b_if.wdata = 0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("rst_addr_ok", 32'(a_if.addr_ok), 32'd1);
        check("rst_data_ok", 32'(a_if.data_ok), 32'd0);
        check("rst_rdata", a_if.rdata, 32'h0);
        idle(10);

        // Byte-strobe merge, three back-to-back accepts.
        issue(1'b1, 32'h100, 4'b1111, 32'hAABBCCDD);
        issue(1'b1, 32'h102, 4'b0100, 32'h11220000);
        issue(1'b0, 32'h100, 4'b0000, 32'h0);
        drain();
        check("bstrb_rdata", a_if.rdata, 32'hAA22CCDD);

        // Ordering, with store responses interleaved between loads.
        for (int i = 0; i < 8; i++) issue(1'b1, 32'(i * 4), 4'b1111, 32'(i));
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 32'(i * 4), 4'b0000, 32'h0);
            issue(1'b1, 32'h200, 4'b1111, $urandom);
        end
        drain();
        check("order_last", a_if.rdata, 32'h7);

        // Out-of-range word address wraps onto word 0.
        issue(1'b1, 32'h1000, 4'b1111, 32'h12345678);
        issue(1'b0, 32'h0, 4'b0000, 32'h0);
        drain();
        check("wrap_rdata", a_if.rdata, 32'h12345678);

        // Random mix over the written words 0..7, with random strobes and gaps.
        repeat (40) begin
            if ($urandom_range(0, 1) == 1)
                issue(1'b1, 32'($urandom_range(0, 7) * 4), 4'($urandom_range(0, 15)), $urandom);
            else
                issue(1'b0, 32'($urandom_range(0, 7) * 4), 4'b0000, 32'h0);
            idle($urandom_range(0, 2));
        end
        drain();

        // Reset with two loads in flight.
        issue(1'b0, 32'h100, 4'b0000, 32'h0);
        issue(1'b0, 32'h0, 4'b0000, 32'h0);
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(3);
        check("mid_rst_addr_ok", 32'(a_if.addr_ok), 32'd1);
        check("mid_rst_rdata", a_if.rdata, 32'h0);
        check("mid_rst_cnt", 32'(cnt_a), 32'd0);
        issue(1'b0, 32'h100, 4'b0000, 32'h0);
        drain();
        check("post_rst_rdata", a_if.rdata, 32'hAA22CCDD);

        // Back-pressure on the LAT=3, DEPTH=2 instance with req held high.
        b_if.req = 1'b1;
        idle(30);
        b_if.req = 1'b0;
        idle(6);
        check("b_idle_cnt", 32'(cnt_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
